// File: rtl/addsub_pipe_if.sv
// Valid/ready stream bundle for addsub_pipe: operands and op flags in, result and overflow out.
interface addsub_pipe_if #(
  parameter int a_bits = 32,
  parameter int b_bits = 32,
  parameter int q_bits = 32
);
  logic              i_valid;
  logic              o_ready;
  logic [a_bits-1:0] i_a;
  logic [b_bits-1:0] i_b;
  logic              i_sub;
  logic              i_sat;
  logic              o_valid;
  logic              i_ready;
  logic [q_bits-1:0] o_q;
  logic              o_ovf;

  // Upstream/downstream side that drives operands and consumes results.
  modport master (
    output i_valid, i_a, i_b, i_sub, i_sat, i_ready,
    input  o_ready, o_valid, o_q, o_ovf
  );

  // The adder/subtractor itself.
  modport slave (
    input  i_valid, i_a, i_b, i_sub, i_sat, i_ready,
    output o_ready, o_valid, o_q, o_ovf
  );
endinterface

// File: rtl/addsub_pipe.sv
// Pipelined adder/subtractor with signed/unsigned operands, optional saturation,
// overflow flag and a stall-everything valid/ready handshake. The whole result is
// formed in stage 0; the remaining stages are a plain delay line.
module addsub_pipe #(
  parameter int latency     = 3,
  parameter int a_bits      = 32,
  parameter int b_bits      = 32,
  parameter int q_bits      = 32,
  parameter bit signed_mode = 1'b0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  addsub_pipe_if.slave bus
);

  // Exact arithmetic width: one bit for carry/borrow, one for the sign of a difference.
  localparam int ab_max = (a_bits > b_bits) ? a_bits : b_bits;
  localparam int w_bits = ab_max + 2;
  // Check width is strictly wider than both r and q, so range tests are plain bit tests.
  localparam int c_bits = ((w_bits > q_bits) ? w_bits : q_bits) + 1;

  logic                en;
  logic [w_bits-1:0]   a_ext;
  logic [w_bits-1:0]   b_ext;
  logic [w_bits-1:0]   r;
  logic [c_bits-1:0]   r_c;
  logic                fit_s;
  logic                fit_u;
  logic                fits;
  logic                neg;
  logic [q_bits-1:0]   max_pos;
  logic [q_bits-1:0]   min_neg;
  logic [q_bits-1:0]   sat_val;

  logic [latency-1:0]  vld_q;
  logic [latency-1:0]  vld_d;
  logic [latency-1:0]  ovf_q;
  logic [latency-1:0]  ovf_d;
  logic [q_bits-1:0]   res_q [latency];
  logic [q_bits-1:0]   res_d [latency];

  // Stage 0 arithmetic: extend, add/sub exactly, then decide fit and the final result.
  always_comb begin
    a_ext   = {{(w_bits-a_bits){signed_mode & bus.i_a[a_bits-1]}}, bus.i_a};
    b_ext   = {{(w_bits-b_bits){signed_mode & bus.i_b[b_bits-1]}}, bus.i_b};
    r       = bus.i_sub ? (a_ext - b_ext) : (a_ext + b_ext);
    // r is always a correct two's complement value in w_bits, even for unsigned operands.
    r_c     = {{(c_bits-w_bits){r[w_bits-1]}}, r};
    neg     = r_c[c_bits-1];
    // Signed fit: every bit from the q sign bit upward is a copy of the sign.
    fit_s   = (r_c[c_bits-1:q_bits-1] == '0) || (r_c[c_bits-1:q_bits-1] == '1);
    // Unsigned fit: nothing set above the q field, which also rejects negatives.
    fit_u   = (r_c[c_bits-1:q_bits] == '0);
    fits    = signed_mode ? fit_s : fit_u;
    max_pos = '1;
    max_pos[q_bits-1] = 1'b0;
    min_neg = '0;
    min_neg[q_bits-1] = 1'b1;
    if (signed_mode) begin
      sat_val = neg ? min_neg : max_pos;
    end else begin
      sat_val = neg ? '0 : '1;
    end
  end

  // Next-state for every stage: stage 0 takes the new result, others shift.
  always_comb begin
    vld_d    = '0;
    ovf_d    = '0;
    for (int i = 0; i < latency; i++) begin
      res_d[i] = '0;
    end
    vld_d[0] = bus.i_valid;
    ovf_d[0] = !fits;
    res_d[0] = (fits || !bus.i_sat) ? r_c[q_bits-1:0] : sat_val;
    for (int i = 1; i < latency; i++) begin
      vld_d[i] = vld_q[i-1];
      ovf_d[i] = ovf_q[i-1];
      res_d[i] = res_q[i-1];
    end
  end

  // Pipeline registers: reset clears everything, otherwise advance only when enabled.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_q <= '0;
      ovf_q <= '0;
      for (int i = 0; i < latency; i++) begin
        res_q[i] <= '0;
      end
    end else if (en) begin
      vld_q <= vld_d;
      ovf_q <= ovf_d;
      for (int i = 0; i < latency; i++) begin
        res_q[i] <= res_d[i];
      end
    end
  end

  // Whole pipe moves unless a finished result is waiting on downstream.
  assign en          = !vld_q[latency-1] || bus.i_ready;
  assign bus.o_ready = en;
  assign bus.o_valid = vld_q[latency-1];
  assign bus.o_q     = res_q[latency-1];
  assign bus.o_ovf   = ovf_q[latency-1];

endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe: three configurations, scoreboard queues fed at accept
// and drained at consume, with literal vectors plus a reference model.
module tb_addsub_pipe;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 i_clk = ~i_clk;

  // s: signed 8/8/8 latency 3; u: unsigned 8/8/8 latency 3; w: signed 8/4/16 latency 1
  addsub_pipe_if #(.a_bits(8), .b_bits(8), .q_bits(8))  s_if ();
  addsub_pipe_if #(.a_bits(8), .b_bits(8), .q_bits(8))  u_if ();
  addsub_pipe_if #(.a_bits(8), .b_bits(4), .q_bits(16)) w_if ();

  addsub_pipe #(.latency(3), .a_bits(8), .b_bits(8), .q_bits(8), .signed_mode(1'b1))
    u_s (.i_clk(i_clk), .i_rst(i_rst), .bus(s_if));
  addsub_pipe #(.latency(3), .a_bits(8), .b_bits(8), .q_bits(8), .signed_mode(1'b0))
    u_u (.i_clk(i_clk), .i_rst(i_rst), .bus(u_if));
  addsub_pipe #(.latency(1), .a_bits(8), .b_bits(4), .q_bits(16), .signed_mode(1'b1))
    u_w (.i_clk(i_clk), .i_rst(i_rst), .bus(w_if));

  logic [16:0] s_sb [$];
  logic [16:0] u_sb [$];
  logic [16:0] w_sb [$];
  logic [15:0] s_eq, u_eq, w_eq;
  logic        s_eo, u_eo, w_eo;
  int          s_got = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: exact integer result, range test, then wrap or clamp. Returns {ovf, q}.
  function automatic logic [16:0] model(longint a, longint b, bit sub, bit sat, int qb, bit sgn);
    longint      r, lo, hi;
    logic [63:0] rv;
    bit          fit;
    r = sub ? a - b : a + b;
    if (sgn) begin
      hi = (longint'(1) <<< (qb - 1)) - 1;
      lo = -hi - 1;
    end else begin
      hi = (longint'(1) <<< qb) - 1;
      lo = 0;
    end
    fit = (r >= lo) && (r <= hi);
    if (fit || !sat) rv = r;
    else if (r > hi) rv = hi;
    else rv = lo;
    return {!fit, rv[15:0]};
  endfunction

  // Scoreboards: push on accept, pop and compare on consume, flush on reset.
  always @(negedge i_clk) begin
    logic [16:0] e;
    if (i_rst) begin
      s_sb.delete(); u_sb.delete(); w_sb.delete();
    end else begin
      if (s_if.i_valid && s_if.o_ready) s_sb.push_back({s_eo, s_eq});
      if (u_if.i_valid && u_if.o_ready) u_sb.push_back({u_eo, u_eq});
      if (w_if.i_valid && w_if.o_ready) w_sb.push_back({w_eo, w_eq});
      if (s_if.o_valid && s_if.i_ready) begin
        if (s_sb.size() == 0) chk("s_stale", 32'(s_if.o_valid), 32'd0);
        else begin
          e = s_sb.pop_front();
          $display("s: q=%h ovf=%b exp q=%h ovf=%b", s_if.o_q, s_if.o_ovf, e[7:0], e[16]);
          chk("s_q", 32'(s_if.o_q), 32'(e[7:0]));
          chk("s_ovf", 32'(s_if.o_ovf), 32'(e[16]));
          s_got++;
        end
      end
      if (u_if.o_valid && u_if.i_ready) begin
        if (u_sb.size() == 0) chk("u_stale", 32'(u_if.o_valid), 32'd0);
        else begin
          e = u_sb.pop_front();
          $display("u: q=%h ovf=%b exp q=%h ovf=%b", u_if.o_q, u_if.o_ovf, e[7:0], e[16]);
          chk("u_q", 32'(u_if.o_q), 32'(e[7:0]));
          chk("u_ovf", 32'(u_if.o_ovf), 32'(e[16]));
        end
      end
      if (w_if.o_valid && w_if.i_ready) begin
        if (w_sb.size() == 0) chk("w_stale", 32'(w_if.o_valid), 32'd0);
        else begin
          e = w_sb.pop_front();
          $display("w: q=%h ovf=%b exp q=%h ovf=%b", w_if.o_q, w_if.o_ovf, e[15:0], e[16]);
          chk("w_q", 32'(w_if.o_q), 32'(e[15:0]));
          chk("w_ovf", 32'(w_if.o_ovf), 32'(e[16]));
        end
      end
    end
  end

  function automatic logic outv(int which);
    case (which)
      0:       return s_if.o_valid;
      1:       return u_if.o_valid;
      default: return w_if.o_valid;
    endcase
  endfunction

  // One isolated transaction with downstream ready; also measures accept-to-valid latency.
  task automatic send(int which, logic [7:0] a, logic [7:0] b, bit sub, bit sat,
                      logic [15:0] eq, bit eo, int exp_lat);
    int lat;
    case (which)
      0: begin
        s_if.i_a = a; s_if.i_b = b; s_if.i_sub = sub; s_if.i_sat = sat;
        s_eq = eq; s_eo = eo; s_if.i_valid = 1'b1;
      end
      1: begin
        u_if.i_a = a; u_if.i_b = b; u_if.i_sub = sub; u_if.i_sat = sat;
        u_eq = eq; u_eo = eo; u_if.i_valid = 1'b1;
      end
      default: begin
        w_if.i_a = a; w_if.i_b = b[3:0]; w_if.i_sub = sub; w_if.i_sat = sat;
        w_eq = eq; w_eo = eo; w_if.i_valid = 1'b1;
      end
    endcase
    @(posedge i_clk); #1;
    s_if.i_valid = 1'b0; u_if.i_valid = 1'b0; w_if.i_valid = 1'b0;
    lat = 1;
    while (!outv(which) && lat < 20) begin
      @(posedge i_clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [16:0] e;
    logic [7:0]  ra, rb;
    bit          rs, rt;
    int          sent;
    int          got0;
    bit          stall_prev;
    logic [7:0]  prev_q;
    logic        prev_ovf;

    s_if.i_valid = 0; s_if.i_a = 0; s_if.i_b = 0; s_if.i_sub = 0; s_if.i_sat = 0; s_if.i_ready = 1;
    u_if.i_valid = 0; u_if.i_a = 0; u_if.i_b = 0; u_if.i_sub = 0; u_if.i_sat = 0; u_if.i_ready = 1;
    w_if.i_valid = 0; w_if.i_a = 0; w_if.i_b = 0; w_if.i_sub = 0; w_if.i_sat = 0; w_if.i_ready = 1;
    s_eq = 0; u_eq = 0; w_eq = 0; s_eo = 0; u_eo = 0; w_eo = 0;

    // Reset state of all three instances
    repeat (3) @(posedge i_clk);
    #1 i_rst = 1'b0;
    chk("s_rst_valid", 32'(s_if.o_valid), 32'd0);
    chk("s_rst_q",     32'(s_if.o_q),     32'd0);
    chk("s_rst_ovf",   32'(s_if.o_ovf),   32'd0);
    chk("u_rst_valid", 32'(u_if.o_valid), 32'd0);
    chk("w_rst_valid", 32'(w_if.o_valid), 32'd0);
    chk("w_rst_q",     32'(w_if.o_q),     32'd0);

    // Signed 8-bit: wrap, saturate high, saturate low, exact boundaries
    send(0, 8'd100, 8'd50, 0, 0, 16'h0096, 1, 3);
    send(0, 8'd100, 8'd50, 0, 1, 16'h007F, 1, 3);
    send(0, 8'h9C,  8'hCE, 0, 1, 16'h0080, 1, 3);   // -100 + -50
    send(0, 8'h9C,  8'hCE, 0, 0, 16'h006A, 1, 3);   // -150 wraps to 0x6A
    send(0, 8'h80,  8'h01, 1, 1, 16'h0080, 1, 3);   // -128 - 1 clamps
    send(0, 8'd127, 8'h00, 0, 1, 16'h007F, 0, 3);   // max positive fits
    send(0, 8'h81,  8'h01, 1, 1, 16'h0080, 0, 3);   // -127 - 1 = -128 fits

    // Unsigned 8-bit: underflow saturate/wrap, top of range
    send(1, 8'd5,   8'd10, 1, 1, 16'h0000, 1, 3);
    send(1, 8'd5,   8'd10, 1, 0, 16'h00FB, 1, 3);
    send(1, 8'd200, 8'd55, 0, 0, 16'h00FF, 0, 3);
    send(1, 8'd200, 8'd56, 0, 1, 16'h00FF, 1, 3);

    // Width extension with latency 1
    send(2, 8'h80, 8'h08, 0, 0, 16'hFF78, 0, 1);   // -128 + -8
    send(2, 8'h80, 8'h07, 1, 1, 16'hFF79, 0, 1);   // -128 - 7
    send(2, 8'd127, 8'h08, 1, 0, 16'h0087, 0, 1);  // 127 - (-8)

    // Random vectors checked against the reference model
    for (int k = 0; k < 6; k++) begin
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom); rt = 1'($urandom);
      e = model(longint'($signed(ra)), longint'($signed(rb)), rs, rt, 8, 1);
      send(0, ra, rb, rs, rt, e[15:0], e[16], 3);
      e = model(longint'(ra), longint'(rb), rs, rt, 8, 0);
      send(1, ra, rb, rs, rt, e[15:0], e[16], 3);
    end
    repeat (2) begin @(posedge i_clk); #1; end

    // Streaming with a downstream stall on cycles 5..8
    sent = 0;
    got0 = s_got;
    stall_prev = 0;
    prev_q = 0;
    prev_ovf = 0;
    for (int c = 0; c < 40; c++) begin
      s_if.i_ready = !(c >= 5 && c <= 8);
      if (sent < 10) begin
        s_if.i_valid = 1; s_if.i_a = 8'(sent); s_if.i_b = 8'd1; s_if.i_sub = 0; s_if.i_sat = 0;
        s_eq = 16'(sent + 1); s_eo = 0;
      end else begin
        s_if.i_valid = 0;
      end
      @(negedge i_clk);
      chk("s_oready", 32'(s_if.o_ready), 32'(!(s_if.o_valid && !s_if.i_ready)));
      if (stall_prev) begin
        chk("s_hold_q",   32'(s_if.o_q),   32'(prev_q));
        chk("s_hold_ovf", 32'(s_if.o_ovf), 32'(prev_ovf));
      end
      stall_prev = s_if.o_valid && !s_if.i_ready;
      prev_q = s_if.o_q;
      prev_ovf = s_if.o_ovf;
      if (s_if.i_valid && s_if.o_ready) sent++;
      @(posedge i_clk); #1;
    end
    s_if.i_ready = 1;
    chk("s_stream_count", 32'(s_got - got0), 32'd10);
    chk("s_stream_empty", 32'(s_sb.size()), 32'd0);

    // Reset with three transactions in flight
    for (int k = 0; k < 3; k++) begin
      s_if.i_valid = 1; s_if.i_a = 8'(k + 10); s_if.i_b = 8'd1; s_if.i_sub = 0; s_if.i_sat = 0;
      s_eq = 16'(k + 11); s_eo = 0;
      @(posedge i_clk); #1;
    end
    s_if.i_valid = 0;
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    chk("s_mid_rst_valid", 32'(s_if.o_valid), 32'd0);
    chk("s_mid_rst_q",     32'(s_if.o_q),     32'd0);
    chk("s_mid_rst_ovf",   32'(s_if.o_ovf),   32'd0);
    repeat (5) begin @(posedge i_clk); #1; end
    send(0, 8'd7, 8'd3, 1, 0, 16'h0004, 0, 3);
    repeat (3) begin @(posedge i_clk); #1; end
    chk("s_final_empty", 32'(s_sb.size()), 32'd0);
    chk("u_final_empty", 32'(u_sb.size()), 32'd0);
    chk("w_final_empty", 32'(w_sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
